// File: rtl/mont_r_setup.sv
// -----------------------------------------------------------------------------
// mont_r_setup
//   Iterative Montgomery precompute unit. For an odd modulant n and
//   R = 2^DATA_WIDTH it produces
//     r_div_two = 2^(DATA_WIDTH-1) mod n
//     r_squared = 2^(2*DATA_WIDTH) mod n
//   It works by repeated modular doubling of an accumulator that starts at
//   2^0 mod n. The accumulator is tapped after DATA_WIDTH-1 and 2*DATA_WIDTH
//   doublings. The done flag rises 2*DATA_WIDTH edges after the start-accept edge.
//
// Optional feature (macro MONT_RSETUP_NPRIME_EN):
//   Defined   - a Hensel-lifting lane runs during the first DATA_WIDTH RUN
//               cycles and produces n_prime = -n^-1 mod 2^DATA_WIDTH.
//   Undefined - o_n_prime is tied to 0. Ports and latency are unchanged.
//
// Ports
//   i_clk        rising-edge clock
//   i_rst_n      asynchronous reset, active low
//   i_start      request, sampled only in IDLE/DONE
//   i_modulant   n, captured on the accept edge
//   o_r_div_two  2^(DATA_WIDTH-1) mod n
//   o_r_squared  2^(2*DATA_WIDTH) mod n
//   o_n_prime    -n^-1 mod 2^DATA_WIDTH (0 when the lane is not built)
//   o_busy       high while running
//   o_done       sticky completion, cleared by the next accepted start
//   o_error      sticky, set when the captured n is even
// -----------------------------------------------------------------------------
module mont_r_setup #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [DATA_WIDTH-1:0] i_modulant,
    output logic [DATA_WIDTH-1:0] o_r_div_two,
    output logic [DATA_WIDTH-1:0] o_r_squared,
    output logic [DATA_WIDTH-1:0] o_n_prime,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error
);

    localparam int CW = $clog2(2*DATA_WIDTH+1);
    localparam logic [CW-1:0] C_HALF = CW'(DATA_WIDTH-1);
    localparam logic [CW-1:0] C_W    = CW'(DATA_WIDTH);
    localparam logic [CW-1:0] C_END  = CW'(2*DATA_WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [DATA_WIDTH-1:0] r_n;
    logic [CW-1:0]         r_cnt;
    logic [DATA_WIDTH-1:0] r_r_div_two;
    logic [DATA_WIDTH-1:0] r_r_squared;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_error;

    logic                  w_ge;
    logic [DATA_WIDTH-1:0] w_sh_lo;
    logic [DATA_WIDTH-1:0] w_dbl;
    logic [CW-1:0]         w_cnt_nxt;

    // Modular doubling. The compare needs the full (W+1)-bit shifted value.
    // Because acc < n, the difference always fits in W bits, so the subtraction
    // is done on the low W bits with wrap-around.
    assign w_ge      = {r_acc, 1'b0} >= {1'b0, r_n};
    assign w_sh_lo   = {r_acc[DATA_WIDTH-2:0], 1'b0};
    assign w_dbl     = w_ge ? (w_sh_lo - r_n) : w_sh_lo;
    assign w_cnt_nxt = r_cnt + CW'(1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_n         <= '0;
            r_cnt       <= '0;
            r_r_div_two <= '0;
            r_r_squared <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_r_div_two <= '0;
                        r_r_squared <= '0;
                        if (i_modulant[0]) begin
                            r_n     <= i_modulant;
                            // n == 1: every residue is 0, so start the chain at 0
                            r_acc   <= (i_modulant == DATA_WIDTH'(1)) ? '0 : DATA_WIDTH'(1);
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                            r_error <= 1'b0;
                            r_state <= S_RUN;
                        end else begin
                            // even modulant: finish at once with an error
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_error <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    r_acc <= w_dbl;
                    r_cnt <= w_cnt_nxt;
                    if (w_cnt_nxt == C_HALF)
                        r_r_div_two <= w_dbl;
                    if (w_cnt_nxt == C_END) begin
                        r_r_squared <= w_dbl;
                        r_done      <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_r_div_two = r_r_div_two;
    assign o_r_squared = r_r_squared;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_error     = r_error;

`ifdef MONT_RSETUP_NPRIME_EN
    // Hensel lane: bit i of x is fixed on RUN cycle i (i = old cnt). It shares
    // the RUN timeline, so it adds no latency.
    logic                  w_accept;
    logic [DATA_WIDTH:0]   r_s;
    logic [DATA_WIDTH-1:0] r_x;
    logic [DATA_WIDTH-1:0] r_n_prime;
    logic [DATA_WIDTH:0]   w_s_add;
    logic [DATA_WIDTH:0]   w_s_nxt;
    logic [DATA_WIDTH-1:0] w_x_nxt;

    assign w_accept = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
    // s <= n holds throughout, so s + n fits in W+1 bits
    assign w_s_add  = r_s[0] ? (r_s + {1'b0, r_n}) : r_s;
    assign w_s_nxt  = w_s_add >> 1;

    always_comb begin
        w_x_nxt = r_x;
        for (int i = 0; i < DATA_WIDTH; i++)
            if ((r_cnt == CW'(i)) && r_s[0])
                w_x_nxt[i] = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s       <= '0;
            r_x       <= '0;
            r_n_prime <= '0;
        end else if (w_accept) begin
            r_s       <= {{DATA_WIDTH{1'b0}}, 1'b1};
            r_x       <= '0;
            r_n_prime <= '0;
        end else if ((r_state == S_RUN) && (r_cnt < C_W)) begin
            r_s <= w_s_nxt;
            r_x <= w_x_nxt;
            if (w_cnt_nxt == C_W)
                r_n_prime <= w_x_nxt;
        end
    end

    assign o_n_prime = r_n_prime;
`else
    assign o_n_prime = '0;
`endif

endmodule

// File: tb/tb_mont_r_setup.sv
// -----------------------------------------------------------------------------
// tb_mont_r_setup
//   Scoreboarded bench for mont_r_setup (DATA_WIDTH=8). Expected results come
//   from a behavioural reference model (modular exponent by division, n_prime
//   by search). They are queued at start, then popped and compared when done rises.
// -----------------------------------------------------------------------------
module tb_mont_r_setup;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] modulant = '0;
    logic [W-1:0] r_div_two, r_squared, n_prime;
    logic         busy, done, error;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [W-1:0] rdt;
        logic [W-1:0] rsq;
        logic [W-1:0] np;
        logic         err;
        logic         chk_np;
    } exp_t;

    exp_t exp_q[$];

    mont_r_setup #(.DATA_WIDTH(W)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_modulant  (modulant),
        .o_r_div_two (r_div_two),
        .o_r_squared (r_squared),
        .o_n_prime   (n_prime),
        .o_busy      (busy),
        .o_done      (done),
        .o_error     (error)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] n);
        exp_t   e;
        longint nn;
        nn       = longint'(n);
        e.rdt    = '0;
        e.rsq    = '0;
        e.np     = '0;
        e.err    = 1'b0;
        e.chk_np = 1'b1;
        if (n[0] == 1'b0) begin
            e.err = 1'b1;
        end else begin
            e.rdt = W'((64'd1 << (W-1)) % nn);
            e.rsq = W'((64'd1 << (2*W)) % nn);
`ifdef MONT_RSETUP_NPRIME_EN
            for (int x = 0; x < (1 << W); x++)
                if (((nn * longint'(x)) & ((64'd1 << W) - 1)) == ((64'd1 << W) - 1))
                    e.np = W'(x);
            e.chk_np = (n != W'(1));
`endif
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a start for one edge, queue its expectation, and return just after the accept edge.
    task automatic issue(input logic [W-1:0] n);
        start    = 1'b1;
        modulant = n;
        exp_q.push_back(model(n));
        tick();
        start = 1'b0;
    endtask

    // Count edges after the accept edge until done. If glitch_at >= 0, pulse
    // start with modulant=7 at that point (it must be ignored).
    task automatic run_to_done(input string name, input int lat_exp, input int glitch_at);
        int   lat;
        int   busy_cnt;
        exp_t e;
        lat      = 0;
        busy_cnt = 0;
        while (!done && lat < 100) begin
            if (busy) busy_cnt++;
            if (lat == glitch_at) begin
                start    = 1'b1;
                modulant = W'(7);
            end
            tick();
            start = 1'b0;
            lat++;
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s timeout: done=%0b after %0d edges, required 1", name, done, lat);
        end
        n_checks++;
        if (lat !== lat_exp) begin
            n_fail++;
            $display("FAIL %s latency: got %0d, required %0d", name, lat, lat_exp);
        end
        n_checks++;
        if (busy_cnt !== lat_exp || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy: high %0d cycles (now %0b), required %0d then 0",
                     name, busy_cnt, busy, lat_exp);
        end
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s scoreboard: queue empty, required one entry", name);
        end else begin
            e = exp_q.pop_front();
            n_checks++;
            if (r_div_two !== e.rdt) begin
                n_fail++;
                $display("FAIL %s r_div_two: got %0d, required %0d", name, r_div_two, e.rdt);
            end
            n_checks++;
            if (r_squared !== e.rsq) begin
                n_fail++;
                $display("FAIL %s r_squared: got %0d, required %0d", name, r_squared, e.rsq);
            end
            n_checks++;
            if (error !== e.err) begin
                n_fail++;
                $display("FAIL %s error: got %0b, required %0b", name, error, e.err);
            end
            if (e.chk_np) begin
                n_checks++;
                if (n_prime !== e.np) begin
                    n_fail++;
                    $display("FAIL %s n_prime: got %0d, required %0d", name, n_prime, e.np);
                end
            end
            // results must be stable in DONE
            repeat (3) tick();
            n_checks++;
            if (done !== 1'b1 || r_div_two !== e.rdt || r_squared !== e.rsq || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL %s hold: done=%0b rdt=%0d rsq=%0d busy=%0b, required 1/%0d/%0d/0",
                         name, done, r_div_two, r_squared, busy, e.rdt, e.rsq);
            end
        end
    endtask

    task automatic check_all_zero(input string name);
        n_checks++;
        if ({r_div_two, r_squared, n_prime, busy, done, error} !== '0) begin
            n_fail++;
            $display("FAIL %s: rdt=%0d rsq=%0d np=%0d busy=%0b done=%0b err=%0b, required all 0",
                     name, r_div_two, r_squared, n_prime, busy, done, error);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        check_all_zero("reset_async");
        tick();
        tick();
        check_all_zero("reset_held");
        rst_n = 1'b1;
        tick();
        check_all_zero("reset_idle");
    endtask

    task automatic test_basic();
        issue(W'(13));
        run_to_done("n13", 2*W, -1);
        issue(W'(255));
        run_to_done("n255", 2*W, -1);
        issue(W'(3));
        run_to_done("n3", 2*W, -1);
    endtask

    task automatic test_even();
        issue(W'(12));
        run_to_done("n12_even", 0, -1);
    endtask

    task automatic test_ignore_during_run();
        issue(W'(13));
        run_to_done("n13_glitch", 2*W, 5);
    endtask

    task automatic test_reset_mid_run();
        issue(W'(13));
        repeat (7) tick();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midrun_busy: got %0b, required 1", busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrun_reset");
        void'(exp_q.pop_front());
        tick();
        rst_n = 1'b1;
        tick();
        check_all_zero("midrun_after_release");
        issue(W'(1));
        run_to_done("n1", 2*W, -1);
    endtask

    task automatic test_back_to_back();
        issue(W'(13));
        run_to_done("b2b_first", 2*W, -1);
        issue(W'(255));
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b1 || r_div_two !== '0 || r_squared !== '0) begin
            n_fail++;
            $display("FAIL b2b_accept: done=%0b busy=%0b rdt=%0d rsq=%0d, required 0/1/0/0",
                     done, busy, r_div_two, r_squared);
        end
        run_to_done("b2b_second", 2*W, -1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_even();
        test_ignore_during_run();
        test_reset_mid_run();
        test_back_to_back();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
